dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of the single-port data memory.
- Port 0 is the CPU load/store unit; port 1 is the host/debug loader, used for preloading and readback over the TinyTapeout IOs.
- Serialises accesses into a fixed 3-cycle transaction: accept, memory access, response.
- Range-checks addresses so illegal accesses never reach memory, and reports them as errors.

Parameters:
- MEM_WORDS, 64: number of 32-bit words in the attached memory; legal word index 0..MEM_WORDS-1.
- ADDR_W, 32: byte-address width on both ports and the memory side.

Ports:
- CLK  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- p0_req  input  1  CPU request; held with p0_we/p0_addr/p0_wdata stable until p0_accept.
- p0_we  input  1  CPU request is a write when 1, read when 0.
- p0_addr  input  ADDR_W  CPU byte address.
- p0_wdata  input  32  CPU write data.
- p0_accept  output  1  single-cycle pulse: port 0 request latched.
- p0_done  output  1  single-cycle pulse: port 0 transaction complete; rsp_rdata/rsp_err valid.
- p1_req, p1_we, p1_addr, p1_wdata, p1_accept, p1_done: same as port 0, for the host port.
- rsp_rdata  output  32  read data of the completing transaction, shared by both ports.
- rsp_err  output  1  completing transaction was misaligned or out of range.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory byte address.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  memory read data (combinational from mem_addr).
- busy  output  1  high in ACCESS and RESP.

Behaviour:
- Clock and reset: one clock (CLK); reset is synchronous and active-high. All state updates on the rising edge of CLK.
- States: IDLE, ACCESS, RESP. Transitions: IDLE->ACCESS on any req; ACCESS->RESP always; RESP->IDLE always. Throughput is one transaction per 3 cycles.
- Reset values:
  - state=IDLE; rr_ptr=0 (port 0 favoured).
  - All accept/done pulses 0; rsp_rdata=0; rsp_err=0; busy=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - Latched request registers cleared.
- Arbitration (IDLE only):
  - Only one req high: that port wins.
  - Both high: the port given by rr_ptr wins.
  - After every accept, rr_ptr = the index of the port that did not win.
- Accept:
  - Combinational (Mealy) pulse in the IDLE cycle in which a port wins.
  - The same edge latches the winner's we/addr/wdata and its port index, then enters ACCESS.
  - A requester must drop or replace req in the cycle after accept.
  - No accept is issued in ACCESS or RESP; a req held during those states waits.
- Address check on the latched address: ok = (addr[1:0]==0) and (addr[ADDR_W-1:2] < MEM_WORDS).
- ACCESS:
  - mem_addr = latched addr; mem_wdata = latched wdata; mem_we = latched we AND ok.
  - At the end of ACCESS, rsp_rdata <= (ok and not we) ? mem_rdata : 0, and rsp_err <= not ok.
  - mem_we is 0 in every state except ACCESS.
  - mem_addr/mem_wdata hold their last values outside ACCESS.
- RESP:
  - pN_done=1 for the latched winner only; rsp_rdata and rsp_err are valid in this cycle.
  - A write returns rsp_rdata=0.
  - rsp_rdata and rsp_err hold until the next RESP.
- Latency: req seen in IDLE at cycle T -> accept at T -> memory access at T+1 -> done at T+2 -> next accept possible at T+3.
- Errors: a misaligned or out-of-range access issues no write, returns rdata 0 with err=1, and still completes normally.
- Reset mid-transaction: on the reset edge the FSM returns to IDLE and the latched request is discarded. No done is issued for it, and mem_we=0 in the reset cycle.
- Boundary addresses: 4*(MEM_WORDS-1) is legal; 4*MEM_WORDS and any address with upper bits set are errors. There is no wrap-around.

Test Plan:
- P0 write then read: p0 writes 0xDEADBEEF @0x10; mem_we high for exactly 1 cycle with mem_addr=0x10. p0 then reads 0x10; p0_done 2 cycles after accept with rsp_rdata=0xDEADBEEF, rsp_err=0.
- Simultaneous requests after reset: p0 and p1 both req. p0 is accepted first; p1 is accepted in the next IDLE (3 cycles later). The order repeats round-robin: p0, p1, p0, p1 over 4 transactions with both held high.
- P1 only: p1 reads 0xFC (MEM_WORDS=64) -> stored data, err=0. p1 reads 0x100 -> rsp_rdata=0, rsp_err=1, mem_we never asserted.
- Misaligned write: p0 writes 0x12345678 @0x11 -> mem_we stays 0, p0_done with rsp_err=1. A subsequent read of 0x10 returns the old value unchanged.
- Reset during ACCESS: assert reset in the ACCESS cycle of a p1 write. Required response: no mem_we, no p1_done, busy=0, and the next simultaneous request grants p0.
- Stall hold: hold p0_req during a p1 transaction. p0_accept is not issued during ACCESS or RESP and is issued in the first IDLE cycle afterwards.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of the two requester ports, the shared response
// and the single-port memory side of the data-memory arbiter.
//   p0_* : CPU load/store port      p1_* : host/debug loader port
//   rsp_*: response of the completing transaction (shared by both ports)
//   mem_*: data memory side (mem_rdata is combinational from mem_addr)
//   busy : arbiter is in the middle of a transaction
// slave  = arbiter view, master = requester/memory view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [31:0]       p0_wdata;
  logic              p0_accept;
  logic              p0_done;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [31:0]       p1_wdata;
  logic              p1_accept;
  logic              p1_done;

  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic              busy;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_accept, p0_done,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_accept, p1_done,
    output rsp_rdata, rsp_err,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_accept, p0_done,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_accept, p1_done,
    input  rsp_rdata, rsp_err,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter/sequencer in front of the
// single-port data memory. Every access runs accept -> access -> response
// (3 cycles). Misaligned or out-of-range addresses never reach memory and
// complete with rsp_err=1, rsp_rdata=0.
// Ports:
//   CLK   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : dmem_arbiter_if.slave (requester ports, response, memory side)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting; arbitrate and accept (Mealy) on any request
// S_ACCESS | latched request drives memory; response captured at end
// S_RESP   | done pulse to the latched winner, response valid
module dmem_arbiter #(
  parameter int MEM_WORDS = 64,
  parameter int ADDR_W    = 32
) (
  input  logic          CLK,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [ADDR_W-3:0] LP_WORDS = (ADDR_W-2)'(MEM_WORDS);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_rr_ptr;
  logic              r_port;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;

  logic              w_any_req;
  logic              w_win_port;
  logic              w_accept;
  logic              w_addr_ok;

  always_comb begin
    w_any_req   = bus.p0_req | bus.p1_req;
    // Lone requester wins outright; on contention rr_ptr decides.
    w_win_port  = (bus.p0_req & bus.p1_req) ? r_rr_ptr : bus.p1_req;
    w_accept    = (r_state == S_IDLE) & w_any_req & ~reset;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  assign w_addr_ok = (r_addr[1:0] == 2'b00) && (r_addr[ADDR_W-1:2] < LP_WORDS);

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= 1'b0;
      r_port      <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_port   <= w_win_port;
        r_we     <= w_win_port ? bus.p1_we    : bus.p0_we;
        r_addr   <= w_win_port ? bus.p1_addr  : bus.p0_addr;
        r_wdata  <= w_win_port ? bus.p1_wdata : bus.p0_wdata;
        r_rr_ptr <= ~w_win_port;
      end
      if (r_state == S_ACCESS) begin
        r_rsp_rdata <= (w_addr_ok && !r_we) ? bus.mem_rdata : 32'd0;
        r_rsp_err   <= ~w_addr_ok;
      end
    end
  end

  assign bus.p0_accept = w_accept & ~w_win_port;
  assign bus.p1_accept = w_accept &  w_win_port;
  assign bus.p0_done   = (r_state == S_RESP) & ~r_port;
  assign bus.p1_done   = (r_state == S_RESP) &  r_port;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  // Gated by reset so an aborted transaction cannot write in the reset cycle.
  assign bus.mem_we    = (r_state == S_ACCESS) & r_we & w_addr_ok & ~reset;
  // The latched request registers hold between transactions, so the memory
  // address/data naturally keep their last values outside S_ACCESS.
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int MEM_WORDS = 64;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic CLK = 1'b0;
  logic reset;
  logic mem_clear;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  dmem_arbiter_if #(.ADDR_W(32)) bus ();

  dmem_arbiter #(.MEM_WORDS(MEM_WORDS), .ADDR_W(32)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  // Attached memory
  logic [31:0] tb_mem [MEM_WORDS];
  assign bus.mem_rdata = (bus.mem_addr[31:8] == 24'd0) ? tb_mem[bus.mem_addr[7:2]] : 32'hBAD0_BAD0;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 + i;
  endfunction

  always @(posedge CLK) begin
    if (mem_clear) begin
      for (int i = 0; i < MEM_WORDS; i++) tb_mem[i] <= init_word(i);
    end else if (bus.mem_we) begin
      tb_mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
  end

  // Reference model: memory contents, round-robin favourite, request queues
  logic [31:0] ref_mem [MEM_WORDS];
  int          fav;
  req_t        q0[$];
  req_t        q1[$];
  int          win_log[$];

  function automatic req_t mk(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.we    = 1'($urandom_range(0, 1));
    r.wdata = $urandom();
    case ($urandom_range(0, 5))
      0, 1, 2: r.addr = $urandom_range(0, MEM_WORDS - 1) * 4;
      3:       r.addr = $urandom_range(0, MEM_WORDS - 1) * 4 + $urandom_range(1, 3);
      4:       r.addr = MEM_WORDS * 4 + $urandom_range(0, 63) * 4;
      default: r.addr = ($urandom() & 32'hFFFF_FFFC) | 32'h0001_0000;
    endcase
    return r;
  endfunction

  task automatic present();
    bus.p0_req = (q0.size() > 0);
    if (q0.size() > 0) begin
      bus.p0_we = q0[0].we; bus.p0_addr = q0[0].addr; bus.p0_wdata = q0[0].wdata;
    end
    bus.p1_req = (q1.size() > 0);
    if (q1.size() > 0) begin
      bus.p1_we = q1[0].we; bus.p1_addr = q1[0].addr; bus.p1_wdata = q1[0].wdata;
    end
  endtask

  // Runs every queued request to completion, checking each cycle of each
  // transaction against the model. Starts and ends just after a rising edge.
  task automatic serve(input string tag);
    req_t        t;
    int          win;
    int          guard;
    bit          exp_ok;
    logic [31:0] exp_rd;
    guard = 0;
    while ((q0.size() > 0 || q1.size() > 0) && guard < 64) begin
      guard++;
      present();
      @(negedge CLK);
      if (q0.size() > 0 && q1.size() > 0) win = fav;
      else if (q1.size() > 0)             win = 1;
      else                                win = 0;
      checks++;
      if (bus.p0_accept !== 1'(win == 0) || bus.p1_accept !== 1'(win == 1)) begin
        errors++;
        $display("FAIL %s accept: p0_accept=%b p1_accept=%b, required winner port %0d",
                 tag, bus.p0_accept, bus.p1_accept, win);
      end
      checks++;
      if (bus.busy !== 1'b0 || bus.mem_we !== 1'b0 || bus.p0_done !== 1'b0 || bus.p1_done !== 1'b0) begin
        errors++;
        $display("FAIL %s idle_outputs: busy=%b mem_we=%b done0=%b done1=%b, required all 0",
                 tag, bus.busy, bus.mem_we, bus.p0_done, bus.p1_done);
      end
      t = (win == 1) ? q1.pop_front() : q0.pop_front();
      win_log.push_back(win);
      fav = 1 - win;
      exp_ok = (t.addr % 4 == 0) && (t.addr / 4 < MEM_WORDS);
      exp_rd = (exp_ok && !t.we) ? ref_mem[int'(t.addr / 4)] : 32'd0;

      @(posedge CLK); #1;
      present();
      @(negedge CLK);
      checks++;
      if (bus.mem_we !== 1'(exp_ok && t.we) || bus.mem_addr !== t.addr || bus.mem_wdata !== t.wdata) begin
        errors++;
        $display("FAIL %s access_mem: mem_we=%b addr=%h wdata=%h, required mem_we=%b addr=%h wdata=%h",
                 tag, bus.mem_we, bus.mem_addr, bus.mem_wdata, exp_ok && t.we, t.addr, t.wdata);
      end
      checks++;
      if (bus.busy !== 1'b1 || bus.p0_accept !== 1'b0 || bus.p1_accept !== 1'b0) begin
        errors++;
        $display("FAIL %s access_state: busy=%b acc0=%b acc1=%b, required busy=1 no accept",
                 tag, bus.busy, bus.p0_accept, bus.p1_accept);
      end

      @(posedge CLK); #1;
      @(negedge CLK);
      checks++;
      if (bus.p0_done !== 1'(win == 0) || bus.p1_done !== 1'(win == 1)) begin
        errors++;
        $display("FAIL %s done: done0=%b done1=%b, required port %0d", tag, bus.p0_done, bus.p1_done, win);
      end
      checks++;
      if (bus.rsp_rdata !== exp_rd || bus.rsp_err !== 1'(!exp_ok)) begin
        errors++;
        $display("FAIL %s rsp @%h: rdata=%h err=%b, required rdata=%h err=%b",
                 tag, t.addr, bus.rsp_rdata, bus.rsp_err, exp_rd, !exp_ok);
      end
      checks++;
      if (bus.busy !== 1'b1 || bus.mem_we !== 1'b0 || bus.p0_accept !== 1'b0 || bus.p1_accept !== 1'b0) begin
        errors++;
        $display("FAIL %s resp_state: busy=%b mem_we=%b acc0=%b acc1=%b, required 1 0 0 0",
                 tag, bus.busy, bus.mem_we, bus.p0_accept, bus.p1_accept);
      end
      if (exp_ok && t.we) ref_mem[int'(t.addr / 4)] = t.wdata;
      @(posedge CLK); #1;
    end
    present();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge CLK); #1;
    reset = 1'b0;
    fav = 0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0 ||
        bus.rsp_rdata !== 32'd0 || bus.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: busy=%b mem_we=%b mem_addr=%h mem_wdata=%h rdata=%h err=%b, required all 0",
               bus.busy, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.rsp_rdata, bus.rsp_err);
    end
    @(posedge CLK); #1;
    reset = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.p0_accept !== 1'b0 || bus.p1_accept !== 1'b0 || bus.p0_done !== 1'b0 ||
        bus.p1_done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses: acc0=%b acc1=%b done0=%b done1=%b busy=%b, required all 0",
               bus.p0_accept, bus.p1_accept, bus.p0_done, bus.p1_done, bus.busy);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_p0_write_read();
    q0.push_back(mk(1'b1, 32'h10, 32'hDEAD_BEEF));
    q0.push_back(mk(1'b0, 32'h10, 32'h0));
    serve("p0_wr_rd");
    checks++;
    if (tb_mem[4] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL p0_wr_mem: word 4 = %h, required deadbeef", tb_mem[4]);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    win_log.delete();
    for (int i = 0; i < 2; i++) begin
      q0.push_back(mk(1'b0, 32'(($urandom_range(0, 63)) * 4), 32'h0));
      q1.push_back(mk(1'b0, 32'(($urandom_range(0, 63)) * 4), 32'h0));
    end
    serve("simul");
    checks++;
    if (win_log.size() != 4) begin
      errors++;
      $display("FAIL simul_count: %0d grants, required 4", win_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (win_log[i] != (i % 2)) begin
          errors++;
          $display("FAIL simul_order[%0d]: port %0d, required %0d", i, win_log[i], i % 2);
        end
      end
    end
  endtask

  task automatic test_p1_only();
    q1.push_back(mk(1'b1, 32'hFC, 32'h0BAD_F00D));
    q1.push_back(mk(1'b0, 32'hFC, 32'h0));
    q1.push_back(mk(1'b0, 32'h100, 32'h0));
    q1.push_back(mk(1'b1, 32'h100, 32'h1111_2222));
    serve("p1_only");
  endtask

  task automatic test_misaligned();
    q0.push_back(mk(1'b1, 32'h11, 32'h1234_5678));
    q0.push_back(mk(1'b0, 32'h10, 32'h0));
    serve("misaligned");
    checks++;
    if (tb_mem[4] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL misaligned_mem: word 4 = %h, required deadbeef", tb_mem[4]);
    end
  endtask

  task automatic test_reset_access();
    bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 32'h20; bus.p1_wdata = 32'hA5A5_1234;
    @(negedge CLK);
    checks++;
    if (bus.p1_accept !== 1'b1) begin
      errors++;
      $display("FAIL rst_acc_accept: p1_accept=%b, required 1", bus.p1_accept);
    end
    @(posedge CLK); #1;
    bus.p1_req = 1'b0;
    reset = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_acc_we: mem_we=%b in reset cycle, required 0", bus.mem_we);
    end
    @(posedge CLK); #1;
    reset = 1'b0;
    fav = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++;
      if (bus.busy !== 1'b0 || bus.p1_done !== 1'b0 || bus.mem_we !== 1'b0) begin
        errors++;
        $display("FAIL rst_acc_after[%0d]: busy=%b p1_done=%b mem_we=%b, required 0 0 0",
                 i, bus.busy, bus.p1_done, bus.mem_we);
      end
      @(posedge CLK); #1;
    end
    win_log.delete();
    q0.push_back(mk(1'b0, 32'h20, 32'h0));
    q1.push_back(mk(1'b0, 32'h20, 32'h0));
    serve("rst_acc_next");
    checks++;
    if (win_log.size() < 1 || win_log[0] != 0) begin
      errors++;
      $display("FAIL rst_acc_grant: first grant port %0d, required 0", win_log.size() > 0 ? win_log[0] : -1);
    end
  endtask

  task automatic test_stall();
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 32'h40;
    @(negedge CLK);
    checks++;
    if (bus.p1_accept !== 1'b1 || bus.p0_accept !== 1'b0) begin
      errors++;
      $display("FAIL stall_p1_accept: acc0=%b acc1=%b, required 0 1", bus.p0_accept, bus.p1_accept);
    end
    @(posedge CLK); #1;
    bus.p1_req = 1'b0;
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'h44;
    @(negedge CLK);
    checks++;
    if (bus.p0_accept !== 1'b0) begin
      errors++;
      $display("FAIL stall_access: p0_accept=%b during ACCESS, required 0", bus.p0_accept);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if (bus.p0_accept !== 1'b0 || bus.p1_done !== 1'b1 || bus.rsp_rdata !== ref_mem[16]) begin
      errors++;
      $display("FAIL stall_resp: p0_accept=%b p1_done=%b rdata=%h, required 0 1 %h",
               bus.p0_accept, bus.p1_done, bus.rsp_rdata, ref_mem[16]);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if (bus.p0_accept !== 1'b1) begin
      errors++;
      $display("FAIL stall_idle: p0_accept=%b in first IDLE, required 1", bus.p0_accept);
    end
    @(posedge CLK); #1;
    bus.p0_req = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if (bus.p0_done !== 1'b1 || bus.rsp_rdata !== ref_mem[17] || bus.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL stall_p0_done: done=%b rdata=%h err=%b, required 1 %h 0",
               bus.p0_done, bus.rsp_rdata, bus.rsp_err, ref_mem[17]);
    end
    @(posedge CLK); #1;
    fav = 1;
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int n0, n1;
      n0 = $urandom_range(0, 5);
      n1 = $urandom_range(0, 5);
      for (int i = 0; i < n0; i++) q0.push_back(rand_req());
      for (int i = 0; i < n1; i++) q1.push_back(rand_req());
      serve("random");
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_clear = 1'b1;
    bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
    fav = 0;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
    repeat (2) @(posedge CLK);
    #1;
    mem_clear = 1'b0;
    test_reset();
    test_p0_write_read();
    test_simultaneous();
    test_p1_only();
    test_misaligned();
    test_reset_access();
    test_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
